// File: rtl/mask_accum_if.sv
// Handshake bundle between the compare pipe (in_*) and VRF writeback (out_*).
// The module view is slave; the producer/consumer view is master.
interface mask_accum_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_vec;
    logic [DATA_WIDTH-1:0] in_ben;
    logic                  in_last;

    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_vec;
    logic [BE_WIDTH-1:0]   out_be;

    modport master (
        output in_valid, in_addr, in_vec, in_ben, in_last, out_ready,
        input  in_ready, out_valid, out_addr, out_vec, out_be
    );

    modport slave (
        input  in_valid, in_addr, in_vec, in_ben, in_last, out_ready,
        output in_ready, out_valid, out_addr, out_vec, out_be
    );
endinterface

// File: rtl/mask_accum.sv
// Merges partial mask-compare chunks aimed at one mask word into a single
// VRF write with byte enables; later chunks win on overlapping bits.
module mask_accum #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    mask_accum_if.slave  bus
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] acc_vec, acc_vec_n;
    logic [DATA_WIDTH-1:0] acc_ben, acc_ben_n;
    logic [ADDR_WIDTH-1:0] acc_addr, acc_addr_n;

    logic                  load;
    logic [DATA_WIDTH-1:0] ld_vec, ld_ben;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [BE_WIDTH-1:0]   ld_be;

    logic                  out_free, accept, same_addr;
    logic [DATA_WIDTH-1:0] mrg_vec, mrg_ben, chunk_vec;

    assign out_free     = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = (state != DRAIN) & out_free & rst;
    assign accept       = bus.in_valid & bus.in_ready;
    assign same_addr    = (bus.in_addr == acc_addr);
    assign chunk_vec    = bus.in_vec & bus.in_ben;
    assign mrg_vec      = (acc_vec & ~bus.in_ben) | chunk_vec;
    assign mrg_ben      = acc_ben | bus.in_ben;

    // Next-state, accumulator update and output-load selection
    always_comb begin
        state_n    = state;
        acc_vec_n  = acc_vec;
        acc_ben_n  = acc_ben;
        acc_addr_n = acc_addr;
        load       = 1'b0;
        ld_vec     = '0;
        ld_ben     = '0;
        ld_addr    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_last) begin
                        load    = 1'b1;
                        ld_vec  = chunk_vec;
                        ld_ben  = bus.in_ben;
                        ld_addr = bus.in_addr;
                    end else begin
                        acc_vec_n  = chunk_vec;
                        acc_ben_n  = bus.in_ben;
                        acc_addr_n = bus.in_addr;
                        state_n    = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept && same_addr) begin
                    if (bus.in_last) begin
                        load       = 1'b1;
                        ld_vec     = mrg_vec;
                        ld_ben     = mrg_ben;
                        ld_addr    = acc_addr;
                        acc_vec_n  = '0;
                        acc_ben_n  = '0;
                        acc_addr_n = '0;
                        state_n    = IDLE;
                    end else begin
                        acc_vec_n = mrg_vec;
                        acc_ben_n = mrg_ben;
                    end
                end else if (accept) begin
                    // Address moved on: flush the old word, start fresh
                    load       = 1'b1;
                    ld_vec     = acc_vec;
                    ld_ben     = acc_ben;
                    ld_addr    = acc_addr;
                    acc_vec_n  = chunk_vec;
                    acc_ben_n  = bus.in_ben;
                    acc_addr_n = bus.in_addr;
                    state_n    = bus.in_last ? DRAIN : ACCUM;
                end
            end
            DRAIN: begin
                if (out_free) begin
                    load       = 1'b1;
                    ld_vec     = acc_vec;
                    ld_ben     = acc_ben;
                    ld_addr    = acc_addr;
                    acc_vec_n  = '0;
                    acc_ben_n  = '0;
                    acc_addr_n = '0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Byte enable = any bit enabled within the byte
    always_comb begin
        ld_be = '0;
        for (int unsigned k = 0; k < BE_WIDTH; k++) begin
            ld_be[k] = |ld_ben[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            acc_vec  <= '0;
            acc_ben  <= '0;
            acc_addr <= '0;
        end else begin
            state    <= state_n;
            acc_vec  <= acc_vec_n;
            acc_ben  <= acc_ben_n;
            acc_addr <= acc_addr_n;
        end
    end

    // Output register: holds under backpressure, drops valid after handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_vec   <= '0;
            bus.out_be    <= '0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_addr  <= ld_addr;
            bus.out_vec   <= ld_vec & ld_ben;
            bus.out_be    <= ld_be;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mask_accum.sv
// Directed table-driven bench for mask_accum plus hand-written backpressure
// and asynchronous-reset sequences.
module tb_mask_accum;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mask_accum_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mask_accum #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          v;
        logic [31:0]   addr;
        logic [63:0]   vec;
        logic [63:0]   ben;
        logic          last;
        logic          ordy;
        logic          eirdy;
        logic          eov;
        logic [31:0]   eaddr;
        logic [63:0]   evec;
        logic [7:0]    ebe;
    } vec_t;

    vec_t tbl[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] addr, input logic [63:0] vec,
                                input logic [63:0] ben, input logic last, input logic ordy,
                                input logic eirdy, input logic eov, input logic [31:0] eaddr,
                                input logic [63:0] evec, input logic [7:0] ebe);
        vec_t t;
        t.v = v; t.addr = addr; t.vec = vec; t.ben = ben; t.last = last; t.ordy = ordy;
        t.eirdy = eirdy; t.eov = eov; t.eaddr = eaddr; t.evec = evec; t.ebe = ebe;
        return t;
    endfunction

    // One cycle: drive at negedge, check in_ready before the edge, outputs after it
    task automatic step(input vec_t t, input string nm);
        @(negedge clk);
        bus.in_valid  = t.v;
        bus.in_addr   = t.addr;
        bus.in_vec    = t.vec;
        bus.in_ben    = t.ben;
        bus.in_last   = t.last;
        bus.out_ready = t.ordy;
        #1;
        check({nm, ".in_ready"}, 64'(bus.in_ready), 64'(t.eirdy));
        @(posedge clk);
        #1;
        check({nm, ".out_valid"}, 64'(bus.out_valid), 64'(t.eov));
        if (t.eov) begin
            check({nm, ".out_addr"}, 64'(bus.out_addr), 64'(t.eaddr));
            check({nm, ".out_vec"}, bus.out_vec, t.evec);
            check({nm, ".out_be"}, 64'(bus.out_be), 64'(t.ebe));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_vec    = '0;
        bus.in_ben    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        //           v  addr  vec                    ben                    l  ordy irdy ov eaddr evec                   ebe
        tbl.push_back(mk(1, 32'h10, 64'hFF,          64'hFF,          1, 1, 1, 1, 32'h10, 64'hFF,          8'h01));
        tbl.push_back(mk(0, 32'h0,  64'h0,           64'h0,           0, 1, 1, 0, 32'h0,  64'h0,           8'h00));
        tbl.push_back(mk(1, 32'h20, 64'h0F,          64'h0F,          0, 1, 1, 0, 32'h0,  64'h0,           8'h00));
        tbl.push_back(mk(1, 32'h20, 64'h3000,        64'hFF00,        1, 1, 1, 1, 32'h20, 64'h300F,        8'h03));
        tbl.push_back(mk(1, 32'h30, 64'hFF,          64'hFF,          0, 1, 1, 0, 32'h0,  64'h0,           8'h00));
        tbl.push_back(mk(1, 32'h30, 64'h00,          64'h0F,          1, 1, 1, 1, 32'h30, 64'hF0,          8'h01));
        tbl.push_back(mk(1, 32'h1,  64'h1,           64'h1,           0, 1, 1, 0, 32'h0,  64'h0,           8'h00));
        tbl.push_back(mk(1, 32'h2,  64'h2,           64'h2,           1, 1, 1, 1, 32'h1,  64'h1,           8'h01));
        tbl.push_back(mk(1, 32'h5,  64'hAB,          64'hFF,          1, 1, 0, 1, 32'h2,  64'h2,           8'h01));
        tbl.push_back(mk(1, 32'h5,  64'hAB,          64'hFF,          1, 1, 1, 1, 32'h5,  64'hAB,          8'h01));
        tbl.push_back(mk(1, 32'h6,  64'hFF00_0000_0000_0000, 64'hFF00_0000_0000_0000, 1, 1, 1, 1, 32'h6, 64'hFF00_0000_0000_0000, 8'h80));
        tbl.push_back(mk(1, 32'h7,  64'h1234,        64'h0,           1, 1, 1, 1, 32'h7,  64'h0,           8'h00));
        tbl.push_back(mk(0, 32'h9,  64'hFFFF,        64'hFFFF,        1, 1, 1, 0, 32'h0,  64'h0,           8'h00));
        tbl.push_back(mk(1, 32'h8,  64'hFF,          64'h0,           0, 1, 1, 0, 32'h0,  64'h0,           8'h00));
        tbl.push_back(mk(0, 32'h8,  64'hFF,          64'hFF,          1, 1, 1, 0, 32'h0,  64'h0,           8'h00));
        tbl.push_back(mk(1, 32'h9,  64'h3,           64'h3,           0, 1, 1, 1, 32'h8,  64'h0,           8'h00));
        tbl.push_back(mk(1, 32'h9,  64'h4,           64'h4,           1, 1, 1, 1, 32'h9,  64'h7,           8'h01));
        tbl.push_back(mk(0, 32'h0,  64'h0,           64'h0,           0, 1, 1, 0, 32'h0,  64'h0,           8'h00));

        // Reset state while rst is held low
        #2;
        check("reset.out_valid", 64'(bus.out_valid), 64'd0);
        check("reset.out_addr", 64'(bus.out_addr), 64'd0);
        check("reset.out_vec", bus.out_vec, 64'd0);
        check("reset.out_be", 64'(bus.out_be), 64'd0);
        check("reset.in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure: output pending with out_ready low holds everything
        step(mk(1, 32'h40, 64'h11, 64'hFF, 1, 1, 1, 1, 32'h40, 64'h11, 8'h01), "bp_load");
        for (int i = 0; i < 5; i++) begin
            step(mk(1, 32'h41, 64'h22, 64'hFF, 1, 0, 0, 1, 32'h40, 64'h11, 8'h01),
                 $sformatf("bp_hold%0d", i));
        end
        step(mk(1, 32'h41, 64'h22, 64'hFF, 1, 1, 1, 1, 32'h41, 64'h22, 8'h01), "bp_release");
        step(mk(0, 32'h0, 64'h0, 64'h0, 0, 1, 1, 0, 32'h0, 64'h0, 8'h00), "bp_drain");

        // Asynchronous reset with a partial accumulator and a pending output
        step(mk(1, 32'h3, 64'hF0, 64'hF0, 0, 1, 1, 0, 32'h0, 64'h0, 8'h00), "rst_acc");
        step(mk(1, 32'h4, 64'h1, 64'h1, 0, 0, 1, 1, 32'h3, 64'hF0, 8'h01), "rst_pend");
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid.out_vec", bus.out_vec, 64'd0);
        check("rst_mid.out_addr", 64'(bus.out_addr), 64'd0);
        check("rst_mid.in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_noflush.out_valid", 64'(bus.out_valid), 64'd0);
        step(mk(1, 32'h3, 64'h0F, 64'h0F, 1, 1, 1, 1, 32'h3, 64'h0F, 8'h01), "rst_fresh");
        step(mk(0, 32'h0, 64'h0, 64'h0, 0, 1, 1, 0, 32'h0, 64'h0, 8'h00), "rst_idle0");
        step(mk(0, 32'h0, 64'h0, 64'h0, 0, 1, 1, 0, 32'h0, 64'h0, 8'h00), "rst_idle1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
